// File: rtl/aes_pkg.sv
// ============================================================================
// Module : aes_pkg
// Brief  : Shared AES byte/state types, forward and inverse S-box tables,
//          and the (row, col) -> byte index mapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int STATE_BYTES = 16;

    typedef logic [7:0]                byte_t;
    typedef byte_t [STATE_BYTES-1:0]   state_t;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Bytes are column-major: byte i sits at row i%4, column i/4.
    function automatic int byte_index(input int row, input int col);
        return col * 4 + row;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inv_sbox.sv
// ============================================================================
// Module : inv_sbox
// Brief  : Combinational AES inverse S-box lookup for a single byte.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = INV_SBOX[i_byte];

endmodule

`default_nettype wire

// File: rtl/inv_sub_bytes_seq.sv
// ============================================================================
// Module : inv_sub_bytes_seq
// Brief  : Sequential AES InvSubBytes, BYTES_PER_CYCLE bytes per clock, with
//          valid/ready ports. Optional macro INV_SHIFT_ROWS_EN folds
//          InvShiftRows into the final capture.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int N_CYC = STATE_BYTES / BYTES_PER_CYCLE;
    localparam int CNT_W = (N_CYC > 1) ? $clog2(N_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bpc_check
        $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_work;
    logic             r_out_valid;
    state_t           r_out_data;

    state_t           w_work_next;
    state_t           w_result;
    logic             w_accept;
    logic             w_last;
    byte_t            w_chunk   [N_CYC][BYTES_PER_CYCLE];
    byte_t            w_lut_in  [BYTES_PER_CYCLE];
    byte_t            w_lut_out [BYTES_PER_CYCLE];

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == CNT_LAST);
    assign busy      = (r_state == ST_BUSY) || (r_state == ST_DONE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // state_t packs byte 0 in the MSBs, so byte i lives at packed index 15-i.
    for (genvar c = 0; c < N_CYC; c++) begin : g_chunk
        for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_byte
            assign w_chunk[c][k] = r_work[STATE_BYTES-1-(c*BYTES_PER_CYCLE+k)];
        end
    end

    for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_lut
        if (N_CYC == 1) begin : g_single
            assign w_lut_in[k] = w_chunk[0][k];
        end else begin : g_multi
            assign w_lut_in[k] = w_chunk[r_cnt][k];
        end

        inv_sbox u_inv_sbox (
            .i_byte (w_lut_in[k]),
            .o_byte (w_lut_out[k])
        );
    end

    for (genvar j = 0; j < STATE_BYTES; j++) begin : g_wb
        assign w_work_next[STATE_BYTES-1-j] =
            (r_cnt == CNT_W'(j / BYTES_PER_CYCLE)) ? w_lut_out[j % BYTES_PER_CYCLE]
                                                  : r_work[STATE_BYTES-1-j];
    end

`ifdef INV_SHIFT_ROWS_EN
    // Row r rotates right by r columns: out[r][c] = sub[r][(c-r) mod 4].
    for (genvar r = 0; r < 4; r++) begin : g_isr_row
        for (genvar c = 0; c < 4; c++) begin : g_isr_col
            assign w_result[STATE_BYTES-1-byte_index(r, c)] =
                w_work_next[STATE_BYTES-1-byte_index(r, (c - r + 4) % 4)];
        end
    end
`else
    assign w_result = w_work_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_work  <= in_data;
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_work <= w_work_next;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_result;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_work  <= in_data;
                            r_cnt   <= '0;
                            r_state <= ST_BUSY;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inv_sub_bytes_seq.sv
// ============================================================================
// Module : tb_inv_sub_bytes_seq
// Brief  : Directed self-checking bench for inv_sub_bytes_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inv_sub_bytes_seq;

    localparam logic [127:0] V1 = 128'h637c777bf26b6fc53001672bfed7ab76;
`ifdef INV_SHIFT_ROWS_EN
    localparam logic [127:0] EXP_V1 = 128'h000d0a0704010e0b0805020f0c090603;
`else
    localparam logic [127:0] EXP_V1 = 128'h000102030405060708090a0b0c0d0e0f;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic         sw_in_valid;
    logic [127:0] sw_in_data;
    logic         sw_out_ready;
    logic         sw_in_ready  [4];
    logic         sw_out_valid [4];
    logic [127:0] sw_out_data  [4];
    logic         sw_busy      [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[0]), .in_data(sw_in_data),
        .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready), .out_data(sw_out_data[0]), .busy(sw_busy[0])
    );
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(2)) dut_b2 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[1]), .in_data(sw_in_data),
        .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready), .out_data(sw_out_data[1]), .busy(sw_busy[1])
    );
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(8)) dut_b8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[2]), .in_data(sw_in_data),
        .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready), .out_data(sw_out_data[2]), .busy(sw_busy[2])
    );
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) dut_b16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[3]), .in_data(sw_in_data),
        .out_valid(sw_out_valid[3]), .out_ready(sw_out_ready), .out_data(sw_out_data[3]), .busy(sw_busy[3])
    );

    // Leaves the caller 1 time unit after the handshake edge.
    task automatic send(input logic [127:0] d, output bit ok);
        in_data  = d;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Cycles after the handshake until out_valid; -1 if it never rises.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 40 && lat == -1; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = i;
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b1;
        sw_in_valid  = 1'b0;
        sw_in_data   = '0;
        sw_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 128'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_vector1();
        bit ok;
        int lat;
        out_ready = 1'b1;
        send(V1, ok);
        total++; if (!ok) begin bad++; $display("FAIL v1_handshake got=timeout want=accept"); end
        wait_out(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL v1_latency got=%0d want=4", lat); end
        total++; if (out_data !== EXP_V1) begin bad++; $display("FAIL v1_data got=%h want=%h", out_data, EXP_V1); end
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0)
            begin bad++; $display("FAIL v1_return_idle got=busy%b/valid%b want=0/0", busy, out_valid); end
    endtask

    task automatic test_patterns();
        logic [127:0] pin  [3];
        logic [127:0] pexp [3];
        bit ok;
        int lat;
        pin[0] = {16{8'h16}}; pexp[0] = {16{8'hff}};
        pin[1] = {16{8'h00}}; pexp[1] = {16{8'h52}};
        pin[2] = {16{8'h52}}; pexp[2] = {16{8'h48}};
        out_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            send(pin[p], ok);
            wait_out(lat);
            total++; if (lat !== 4 || out_data !== pexp[p])
                begin bad++; $display("FAIL pattern%0d got=%h lat=%0d want=%h lat=4", p, out_data, lat, pexp[p]); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        int extra;
        out_ready = 1'b0;
        send({16{8'h00}}, ok);
        wait_out(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL b2b_first_latency got=%0d want=4", lat); end
        in_data  = {16{8'h16}};
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (out_data !== {16{8'h52}} || out_valid !== 1'b1)
                begin bad++; $display("FAIL b2b_hold_data cyc=%0d got=%h/%b want=%h/1", i, out_data, out_valid, {16{8'h52}}); end
            total++; if (in_ready !== 1'b0)
                begin bad++; $display("FAIL b2b_hold_in_ready cyc=%0d got=%b want=0", i, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_comb got=%b want=1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b1)
            begin bad++; $display("FAIL b2b_accept got=valid%b/busy%b want=0/1", out_valid, busy); end
        wait_out(lat);
        total++; if (lat !== 4 || out_data !== {16{8'hff}})
            begin bad++; $display("FAIL b2b_second got=%h lat=%0d want=%h lat=4", out_data, lat, {16{8'hff}}); end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL b2b_single_accept got=%0d extra_valid want=0", extra); end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        int lat;
        out_ready = 1'b1;
        send(V1, ok);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 128'h0) begin bad++; $display("FAIL midrst_out_data got=%h want=0", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        send({16{8'h52}}, ok);
        wait_out(lat);
        total++; if (lat !== 4 || out_data !== {16{8'h48}})
            begin bad++; $display("FAIL midrst_fresh got=%h lat=%0d want=%h lat=4", out_data, lat, {16{8'h48}}); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bpc_sweep();
        int lat [4];
        int want_lat [4];
        want_lat[0] = 16; want_lat[1] = 8; want_lat[2] = 2; want_lat[3] = 1;
        for (int d = 0; d < 4; d++) lat[d] = -1;
        sw_out_ready = 1'b0;
        sw_in_data   = V1;
        sw_in_valid  = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            total++; if (sw_in_ready[d] !== 1'b1)
                begin bad++; $display("FAIL sweep_in_ready inst=%0d got=%b want=1", d, sw_in_ready[d]); end
        end
        @(posedge clk);
        #1;
        sw_in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++)
                if (lat[d] == -1 && sw_out_valid[d]) lat[d] = c;
        end
        for (int d = 0; d < 4; d++) begin
            total++; if (lat[d] !== want_lat[d])
                begin bad++; $display("FAIL sweep_latency inst=%0d got=%0d want=%0d", d, lat[d], want_lat[d]); end
            total++; if (sw_out_data[d] !== EXP_V1)
                begin bad++; $display("FAIL sweep_data inst=%0d got=%h want=%h", d, sw_out_data[d], EXP_V1); end
        end
        sw_out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_vector1();
        test_patterns();
        test_back_to_back();
        test_reset_midflight();
        test_bpc_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
